// File: rtl/bfp_block_scaler_if.sv
// Stream bundle for bfp_block_scaler: a 2W-bit accumulator stream in, and a W-bit
// scaled stream out that carries the block exponent and an end-of-block marker.
interface bfp_block_scaler_if #(
    parameter int W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [2*W-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [5:0]      out_exp;
    logic            out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_last
    );
endinterface

// File: rtl/bfp_block_scaler.sv
// Block-floating-point rescaler: buffers N samples of width 2W, then replays them as W-bit samples that share one shift.
// Define BFP_ROUND_EN to get round-half-up with saturation instead of truncation.
module bfp_block_scaler #(
    parameter int W = 16,
    parameter int N = 8
) (
    input  logic             clk,
    input  logic             rst,
    bfp_block_scaler_if.slave bus
);
    localparam int DW = 2 * W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {FILL, DRAIN} state_t;

    state_t          state;
    logic [DW-1:0]   mem [N];
    logic [IW-1:0]   wcnt, rcnt, rd_nxt;
    logic [5:0]      s_run, s_in, s_new;
    logic            wr_fire, rd_fire, wr_last, rd_last;

    // Shift needed so the sample fits in W bits: W minus its redundant sign bits (capped at W).
    function automatic logic [5:0] sample_shift(input logic [DW-1:0] x);
        logic       run;
        logic [5:0] r;
        run = 1'b1;
        r   = '0;
        for (int i = DW - 2; i >= W - 1; i--) begin
            if (run && (x[i] == x[DW-1])) r = r + 6'd1;
            else                          run = 1'b0;
        end
        return 6'(W) - r;
    endfunction

    function automatic logic [W-1:0] scale(input logic [DW-1:0] x, input logic [5:0] sh);
`ifdef BFP_ROUND_EN
        logic signed [DW:0] half, xr, q;
        half = (sh == 6'd0) ? '0 : ((DW+1)'(1) << (sh - 6'd1));
        xr   = {x[DW-1], x} + half;
        q    = xr >>> sh;
        // Only the +half carry can push a result past W bits; clamp toward the sign.
        if ((&q[DW:W-1]) || !(|q[DW:W-1])) return q[W-1:0];
        else if (q[DW])                     return {1'b1, {(W-1){1'b0}}};
        else                                return {1'b0, {(W-1){1'b1}}};
`else
        logic signed [DW-1:0] q;
        q = $signed(x) >>> sh;
        return q[W-1:0];
`endif
    endfunction

    assign wr_fire = bus.in_valid && bus.in_ready;
    assign rd_fire = bus.out_valid && bus.out_ready;
    assign s_in    = sample_shift(bus.in_data);
    assign s_new   = (s_in > s_run) ? s_in : s_run;
    assign wr_last = (wcnt == IW'(N - 1));
    assign rd_last = (rcnt == IW'(N - 1));
    assign rd_nxt  = rcnt + IW'(1);

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wcnt] <= bus.in_data;
    end

    // The output register is loaded one sample ahead: entry into DRAIN presents buf[0],
    // and each accepted output presents the next entry, so a stall holds data and exp.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= FILL;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_exp   <= '0;
            bus.out_last  <= 1'b0;
            wcnt          <= '0;
            rcnt          <= '0;
            s_run         <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (wr_fire) begin
                        if (wr_last) begin
                            wcnt          <= '0;
                            s_run         <= '0;
                            rcnt          <= '0;
                            bus.out_exp   <= s_new;
                            bus.out_data  <= scale(mem[0], s_new);
                            bus.out_last  <= (N == 1);
                            bus.out_valid <= 1'b1;
                            bus.in_ready  <= 1'b0;
                            state         <= DRAIN;
                        end else begin
                            wcnt  <= wcnt + IW'(1);
                            s_run <= s_new;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_fire) begin
                        if (rd_last) begin
                            rcnt          <= '0;
                            bus.out_valid <= 1'b0;
                            bus.out_last  <= 1'b0;
                            bus.in_ready  <= 1'b1;
                            state         <= FILL;
                        end else begin
                            rcnt         <= rd_nxt;
                            bus.out_data <= scale(mem[rd_nxt], bus.out_exp);
                            bus.out_last <= (rd_nxt == IW'(N - 1));
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_bfp_block_scaler.sv
// Self-checking bench for bfp_block_scaler (W=16, N=4) against a plain-arithmetic block model.
module tb_bfp_block_scaler;
    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bfp_block_scaler_if #(.W(W)) bus ();
    bfp_block_scaler #(.W(W), .N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    logic [31:0] blk   [N];
    int          exp_s;
    logic [15:0] exp_d [N];

    // Smallest arithmetic right shift that makes the value fit in a signed 16-bit word.
    function automatic int ref_shift(input logic [31:0] x);
        longint v, q;
        v = longint'($signed(x));
        for (int s = 0; s <= W; s++) begin
            q = v >>> s;
            if (q >= -32768 && q <= 32767) return s;
        end
        return W;
    endfunction

    function automatic logic [15:0] ref_scale(input logic [31:0] x, input int s);
        longint v;
        v = longint'($signed(x));
`ifdef BFP_ROUND_EN
        if (s > 0) v = v + (longint'(1) << (s - 1));
        v = v >>> s;
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`else
        v = v >>> s;
`endif
        return v[15:0];
    endfunction

    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        r = $urandom;
        return $signed(r) >>> $urandom_range(0, 31);
    endfunction

    task automatic model_block();
        exp_s = 0;
        for (int i = 0; i < N; i++) if (ref_shift(blk[i]) > exp_s) exp_s = ref_shift(blk[i]);
        for (int i = 0; i < N; i++) exp_d[i] = ref_scale(blk[i], exp_s);
    endtask

    task automatic push_sample(input logic [31:0] d);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_ready got=%b want=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_block();
        for (int i = 0; i < N; i++) push_sample(blk[i]);
        total++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL first_out_latency got valid=%b in_ready=%b want valid=1 in_ready=0",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic drain_check(input int rdy_pct, input bit junk);
        int i, t;
        i = 0;
        t = 0;
        while (i < N && t < 200) begin
            bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (junk) begin
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
            end
            total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_data !== exp_d[i] ||
                bus.out_exp !== 6'(exp_s) || bus.out_last !== (i == N - 1)) begin
                bad++;
                $display("FAIL drain idx=%0d got v=%b in_rdy=%b d=%h e=%0d l=%b want v=1 in_rdy=0 d=%h e=%0d l=%b",
                         i, bus.out_valid, bus.in_ready, bus.out_data, bus.out_exp, bus.out_last,
                         exp_d[i], exp_s, (i == N - 1));
            end
            if (bus.out_ready) i++;
            @(posedge clk); #1; t++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        total++;
        if (i != N || (rdy_pct == 100 && t != N)) begin
            bad++;
            $display("FAIL drain_count got=%0d cycles=%0d want=%0d", i, t, N);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL drain_end got valid=%b in_ready=%b want valid=0 in_ready=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic check_idle(input string tag);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== 16'h0 ||
            bus.out_exp !== 6'd0 || bus.out_last !== 1'b0) begin
            bad++;
            $display("FAIL %s got rdy=%b v=%b d=%h e=%0d l=%b want rdy=1 v=0 d=0000 e=0 l=0",
                     tag, bus.in_ready, bus.out_valid, bus.out_data, bus.out_exp, bus.out_last);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle("reset_state");
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_idle");
    endtask

    task automatic test_basic();
        blk = '{32'h0000_0010, 32'h0001_0000, 32'hFFFF_FFF0, 32'h0000_0100};
        exp_s = 2;
        exp_d = '{16'h0004, 16'h4000, 16'hFFFC, 16'h0040};
        send_block();
        drain_check(100, 1'b0);
    endtask

    task automatic test_extremes();
        blk = '{32'h8000_0000, 32'h0, 32'h0, 32'h7FFF_FFFF};
        exp_s = 16;
        exp_d = '{16'h8000, 16'h0000, 16'h0000, 16'h7FFF};
        send_block();
        drain_check(100, 1'b0);
        blk = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        exp_s = 0;
        exp_d = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
        send_block();
        drain_check(70, 1'b0);
    endtask

    task automatic test_round();
        blk = '{32'h0000_0003, 32'h0001_0000, 32'h0, 32'h0};
        exp_s = 2;
`ifdef BFP_ROUND_EN
        exp_d = '{16'h0001, 16'h4000, 16'h0000, 16'h0000};
`else
        exp_d = '{16'h0000, 16'h4000, 16'h0000, 16'h0000};
`endif
        send_block();
        drain_check(100, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < N; i++) blk[i] = rand_sample();
            model_block();
            send_block();
            drain_check(50, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        push_sample(rand_sample());
        push_sample(rand_sample());
        pulse_reset();
        check_idle("rst_fill");
        for (int i = 0; i < N; i++) blk[i] = rand_sample();
        model_block();
        send_block();
        drain_check(60, 1'b0);

        for (int i = 0; i < N; i++) blk[i] = rand_sample();
        send_block();
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        pulse_reset();
        for (int c = 0; c < 3; c++) begin
            check_idle("rst_drain");
            @(posedge clk); #1;
        end
        for (int i = 0; i < N; i++) blk[i] = rand_sample();
        model_block();
        send_block();
        drain_check(50, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_round();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
